// File: rtl/reg_dump_pkg.sv
// Shared types and default widths for the register-file dump reader.
package reg_dump_pkg;

   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

   typedef logic [ADDR_W-1:0] raddr_t;

endpackage

// File: rtl/reg_dump_csum.sv
// Rotate-and-XOR checksum accumulator over the dumped words.
module reg_dump_csum #(
   parameter int unsigned DATA_W = reg_dump_pkg::DATA_W
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              clr_i,
   input  logic              en_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] csum_o
);

   logic [DATA_W-1:0] csum_q, csum_d;

   always_comb begin
      csum_d = csum_q;
      if (clr_i) begin
         csum_d = '0;
      end else if (en_i) begin
         csum_d = {csum_q[DATA_W-2:0], csum_q[DATA_W-1]} ^ data_i;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         csum_q <= '0;
      end else begin
         csum_q <= csum_d;
      end
   end

   assign csum_o = csum_q;

endmodule

// File: rtl/reg_dump_reader.sv
// Walks a register-file address range and streams (address, data) pairs over valid/ready.
// Optional checksum accumulator enabled by defining REG_DUMP_CHECKSUM_EN.
module reg_dump_reader #(
   parameter int unsigned ADDR_W = reg_dump_pkg::ADDR_W,
   parameter int unsigned DATA_W = reg_dump_pkg::DATA_W
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] first_addr_i,
   input  logic [ADDR_W-1:0] last_addr_i,
   output logic [ADDR_W-1:0] rf_raddr_o,
   input  logic [DATA_W-1:0] rf_rdata_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [ADDR_W-1:0] out_addr_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] checksum_o
);

   import reg_dump_pkg::*;

   state_t            state_q;
   logic [ADDR_W-1:0] cur_q, end_q, rf_raddr_q, out_addr_q;
   logic [DATA_W-1:0] out_data_q;
   logic              out_valid_q, busy_q, done_q;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         cur_q       <= '0;
         end_q       <= '0;
         rf_raddr_q  <= '0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  cur_q      <= first_addr_i;
                  end_q      <= last_addr_i;
                  rf_raddr_q <= first_addr_i;
                  busy_q     <= 1'b1;
                  state_q    <= READ;
               end
            end
            READ: begin
               out_data_q  <= rf_rdata_i;
               out_addr_q  <= cur_q;
               out_valid_q <= 1'b1;
               state_q     <= SEND;
            end
            SEND: begin
               // out_valid_q is always set here, so ready alone completes the handshake
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  if (cur_q == end_q) begin
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     cur_q      <= cur_q + 1'b1;
                     rf_raddr_q <= cur_q + 1'b1;
                     state_q    <= READ;
                  end
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rf_raddr_o  = rf_raddr_q;
   assign out_valid_o = out_valid_q;
   assign out_addr_o  = out_addr_q;
   assign out_data_o  = out_data_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

`ifdef REG_DUMP_CHECKSUM_EN
   logic csum_clr, csum_en;

   assign csum_clr = (state_q == IDLE) && start_i;
   assign csum_en  = (state_q == SEND) && out_ready_i;

   reg_dump_csum #(
      .DATA_W(DATA_W)
   ) u_csum (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clr_i   (csum_clr),
      .en_i    (csum_en),
      .data_i  (out_data_q),
      .csum_o  (checksum_o)
   );
`else
   assign checksum_o = '0;
`endif

endmodule
